// File: rtl/half_adder_pkg.sv
// rtl/half_adder_pkg.sv - shared constants for the half adder slice
package half_adder_pkg;

  // Default lane count for a plain single-bit half adder.
  localparam int HA_DEFAULT_WIDTH = 1;

  // Default width of the carry event counter.
  localparam int HA_CNT_W = 16;

endpackage : half_adder_pkg

// File: rtl/half_adder_cell.sv
// rtl/half_adder_cell.sv - single-lane combinational half adder
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  // Sum is the lane parity and carry is set only when both bits are high.
  // This means s and c can never both be 1.
  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder_cell

// File: rtl/half_adder.sv
// rtl/half_adder.sv - WIDTH-lane half adder with optional output register and carry counter
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH   = HA_DEFAULT_WIDTH,
  parameter int REG_OUT = 0,
  parameter int CNT_W   = HA_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] Carry,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_count
);

  // The counter stops at all-ones instead of wrapping.
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] carry_c;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;

  // One independent cell per lane.
  // There is no carry chain between lanes.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a (A[i]),
      .b (B[i]),
      .s (sum_c[i]),
      .c (carry_c[i])
    );
  end

  // Register stage.
  // On a qualified cycle it captures the lane results.
  // Otherwise it holds the previous results and drops valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      carry_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q   <= sum_c;
        carry_q <= carry_c;
      end
    end
  end

  // Count captures that produced at least one carry.
  // The count saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_count <= '0;
    end else if (in_valid && (|carry_c) && (carry_count != CNT_MAX)) begin
      carry_count <= carry_count + CNT_W'(1);
    end
  end

  // Output select is fixed at elaboration.
  // The combinational path never touches clk or rst_n.
  // The registered path reads 0 while reset is asserted.
  assign Sum   = (REG_OUT != 0) ? sum_q   : sum_c;
  assign Carry = (REG_OUT != 0) ? carry_q : carry_c;

endmodule : half_adder

// File: tb/tb_half_adder.sv
// tb/tb_half_adder.sv - self-checking bench for half_adder
module tb_half_adder;

  logic clk = 1'b0;
  logic rst_n;

  // u0: WIDTH=1, combinational outputs
  logic        a0, b0, iv0, s0, c0, ov0;
  logic [15:0] cnt0;
  // u1: WIDTH=1, registered outputs, 2-bit counter
  logic        a1, b1, iv1, s1, c1, ov1;
  logic [1:0]  cnt1;
  // u8 (registered) and u8c (combinational) share 8-lane inputs
  logic [7:0]  a8, b8;
  logic        iv8;
  logic [7:0]  s8, c8, s8c, c8c;
  logic        ov8, ov8c;
  logic [15:0] cnt8, cnt8c;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic [7:0] c;
  } vec_t;

  vec_t tab1[4];
  vec_t tab8[5];

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .REG_OUT(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .A(a0), .B(b0), .in_valid(iv0),
    .Sum(s0), .Carry(c0), .out_valid(ov0), .carry_count(cnt0)
  );

  half_adder #(.WIDTH(1), .REG_OUT(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .in_valid(iv1),
    .Sum(s1), .Carry(c1), .out_valid(ov1), .carry_count(cnt1)
  );

  half_adder #(.WIDTH(8), .REG_OUT(1), .CNT_W(16)) u8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .in_valid(iv8),
    .Sum(s8), .Carry(c8), .out_valid(ov8), .carry_count(cnt8)
  );

  half_adder #(.WIDTH(8), .REG_OUT(0), .CNT_W(16)) u8c (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .in_valid(iv8),
    .Sum(s8c), .Carry(c8c), .out_valid(ov8c), .carry_count(cnt8c)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference for one 8-lane operation: each lane is plain integer addition of two bits.
  task automatic ref_add(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] s, output logic [7:0] c, output bit any_c);
    any_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int t;
      t    = int'(a[i]) + int'(b[i]);
      s[i] = ((t % 2) == 1);
      c[i] = ((t / 2) == 1);
      if (t == 2) any_c = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] es, ec, ms, mc;
    logic       mov;
    int         mcnt;
    int         sat_exp[5];
    bit         any_c;

    tab1[0] = '{8'h0, 8'h0, 8'h0, 8'h0};
    tab1[1] = '{8'h0, 8'h1, 8'h1, 8'h0};
    tab1[2] = '{8'h1, 8'h0, 8'h1, 8'h0};
    tab1[3] = '{8'h1, 8'h1, 8'h0, 8'h1};

    tab8[0] = '{8'hF0, 8'h3C, 8'hCC, 8'h30};
    tab8[1] = '{8'h00, 8'h00, 8'h00, 8'h00};
    tab8[2] = '{8'hFF, 8'hFF, 8'h00, 8'hFF};
    tab8[3] = '{8'hAA, 8'h55, 8'hFF, 8'h00};
    tab8[4] = '{8'h81, 8'h01, 8'h80, 8'h01};

    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;

    rst_n = 1'b0;
    a0 = 0; b0 = 0; iv0 = 0;
    a1 = 0; b1 = 0; iv1 = 0;
    a8 = 0; b8 = 0; iv8 = 0;

    #2;
    chk("rst_u1_sum",   s1,   0);
    chk("rst_u1_carry", c1,   0);
    chk("rst_u1_valid", ov1,  0);
    chk("rst_u1_count", cnt1, 0);
    chk("rst_u8_valid", ov8,  0);
    chk("rst_u8_count", cnt8, 0);
    chk("rst_u8_sum",   s8,   0);

    // Truth table on the combinational instance.
    // This runs while reset is held, because the combinational path must ignore reset.
    for (int k = 0; k < 4; k++) begin
      a0 = tab1[k].a[0];
      b0 = tab1[k].b[0];
      #1;
      chk($sformatf("tt_sum_%0d", k),   s0, tab1[k].s[0]);
      chk($sformatf("tt_carry_%0d", k), c0, tab1[k].c[0]);
      #9;
    end

    for (int k = 0; k < 5; k++) begin
      a8 = tab8[k].a;
      b8 = tab8[k].b;
      #1;
      chk($sformatf("w8_sum_%0d", k),   s8c, tab8[k].s);
      chk($sformatf("w8_carry_%0d", k), c8c, tab8[k].c);
    end

    @(negedge clk);
    rst_n = 1'b1;

    // The first capture after release must happen on the next edge.
    // The 2-bit counter must saturate at 3 and not wrap.
    a1 = 1; b1 = 1; iv1 = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        chk("cap11_sum",   s1,  0);
        chk("cap11_carry", c1,  1);
        chk("cap11_valid", ov1, 1);
      end
      chk($sformatf("sat_count_%0d", k), cnt1, sat_exp[k]);
    end

    // Assert reset between edges while a result is valid and the count is 2.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_valid", ov1,  1);
    chk("pre_rst_count", cnt1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ov1,  0);
    chk("async_rst_count", cnt1, 0);
    chk("async_rst_sum",   s1,   0);
    chk("async_rst_carry", c1,   0);

    // Capture a 1/0 result, then hold with in_valid low while A/B toggle.
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1; b1 = 0; iv1 = 1;
    @(posedge clk); #1;
    chk("cap10_sum",   s1,   1);
    chk("cap10_carry", c1,   0);
    chk("cap10_valid", ov1,  1);
    chk("cap10_count", cnt1, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      iv1 = 0;
      a1  = (k != 1);
      b1  = (k == 0);
      @(posedge clk); #1;
      chk($sformatf("hold_sum_%0d", k),   s1,   1);
      chk($sformatf("hold_carry_%0d", k), c1,   0);
      chk($sformatf("hold_valid_%0d", k), ov1,  0);
      chk($sformatf("hold_count_%0d", k), cnt1, 0);
    end

    // Random sweep on 8 lanes.
    // Model: hold the last captured lane sums, set valid one cycle later,
    // and saturate a carry-event count.
    ms = 0; mc = 0; mov = 0; mcnt = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      iv8 = ($urandom_range(0, 3) != 0);
      ref_add(a8, b8, es, ec, any_c);
      #1;
      chk("rnd_comb_sum",   s8c, es);
      chk("rnd_comb_carry", c8c, ec);
      @(posedge clk); #1;
      mov = iv8;
      if (iv8) begin
        ms = es;
        mc = ec;
        if (any_c && mcnt < 65535) mcnt = mcnt + 1;
      end
      chk("rnd_reg_sum",    s8,    ms);
      chk("rnd_reg_carry",  c8,    mc);
      chk("rnd_reg_valid",  ov8,   mov);
      chk("rnd_reg_count",  cnt8,  mcnt);
      chk("rnd_comb_count", cnt8c, mcnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_half_adder
